// File: rtl/visual_mode_scheduler_pkg.sv
// Shared definitions for the visual mode scheduler: default video timing,
// datapath widths, mode index type and encodings, and the mode FSM states.
package visual_mode_scheduler_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_TOTAL_DEF  = 800;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_TOTAL_DEF  = 525;

   localparam int COORD_W  = 10;
   localparam int AUDIO_W  = 16;
   localparam int COLOUR_W = 8;
   localparam int RGB_W    = 3 * COLOUR_W;
   localparam int MODE_W   = 2;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [AUDIO_W-1:0] audio_t;
   typedef logic [RGB_W-1:0]   rgb_t;
   typedef logic [MODE_W-1:0]  mode_t;

   localparam mode_t MODE_0 = 2'd0;
   localparam mode_t MODE_1 = 2'd1;
   localparam mode_t MODE_2 = 2'd2;
   localparam mode_t MODE_3 = 2'd3;

   typedef enum logic {
      ST_RUN,
      ST_PEND
   } modeState_e;

   // Next mode in the cycle, wrapping from the last implemented mode to mode 0.
   function automatic mode_t nextMode(input mode_t cur, input mode_t last);
      return (cur == last) ? MODE_0 : mode_t'(cur + 2'd1);
   endfunction

endpackage

// File: rtl/visual_raster_counter.sv
// Raster scanner: walks X across each line and Y down each frame, one step
// per pixel strobe, and flags the visible area and the frame wrap to (0,0).
module visual_raster_counter
   import visual_mode_scheduler_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_TOTAL  = H_TOTAL_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_TOTAL  = V_TOTAL_DEF
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   pixEn_i,
   output coord_t x_o,
   output coord_t y_o,
   output logic   visible_o,
   output logic   wrap_o
);

   localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);
   localparam coord_t X_VIS  = coord_t'(H_ACTIVE);
   localparam coord_t Y_VIS  = coord_t'(V_ACTIVE);

   coord_t xQ, xD, yQ, yD;
   logic   lastX, lastY;

   assign lastX     = (xQ == X_LAST);
   assign lastY     = (yQ == Y_LAST);
   assign wrap_o    = pixEn_i && lastX && lastY;
   assign visible_o = (xQ < X_VIS) && (yQ < Y_VIS);
   assign x_o       = xQ;
   assign y_o       = yQ;

   // Next raster position: advance only on a strobe, carry X into Y at line end.
   always_comb begin
      xD = xQ;
      yD = yQ;
      if (pixEn_i) begin
         if (lastX) begin
            xD = '0;
            yD = lastY ? '0 : coord_t'(yQ + 10'd1);
         end else begin
            xD = coord_t'(xQ + 10'd1);
         end
      end
   end

   // Raster position registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         xQ <= '0;
         yQ <= '0;
      end else begin
         xQ <= xD;
         yQ <= yD;
      end
   end

endmodule

// File: rtl/visual_mode_scheduler.sv
// Top of the effect sequencer: scans the raster, freezes audio once per frame,
// steps the active effect mode only at frame wraps, and registers the pixel.
module visual_mode_scheduler
   import visual_mode_scheduler_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int H_TOTAL     = H_TOTAL_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int N_MODES     = 3,
   parameter int AUTO_FRAMES = 300
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iPIX_EN,
   input  logic                iAUD_VALID,
   input  logic [AUDIO_W-1:0]  iL,
   input  logic [AUDIO_W-1:0]  iR,
   input  logic                iMODE_NEXT,
   input  logic                iAUTO_EN,
   input  logic [RGB_W-1:0]    iRGB_0,
   input  logic [RGB_W-1:0]    iRGB_1,
   input  logic [RGB_W-1:0]    iRGB_2,
   input  logic [RGB_W-1:0]    iRGB_3,
   output logic [COORD_W-1:0]  oX,
   output logic [COORD_W-1:0]  oY,
   output logic [AUDIO_W-1:0]  oAUD_L,
   output logic [AUDIO_W-1:0]  oAUD_R,
   output logic [MODE_W-1:0]   oMODE,
   output logic                oFRAME_START,
   output logic                oBLANK_N,
   output logic [COLOUR_W-1:0] oVGA_R,
   output logic [COLOUR_W-1:0] oVGA_G,
   output logic [COLOUR_W-1:0] oVGA_B
);

   localparam bit AUTO_ON = (AUTO_FRAMES != 0);
   localparam int FC_W    = (AUTO_FRAMES < 1) ? 1 : $clog2(AUTO_FRAMES + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'((AUTO_FRAMES < 1) ? 0 : AUTO_FRAMES - 1);
   localparam mode_t MODE_LAST = mode_t'(N_MODES - 1);

   logic frameWrap;
   logic visible;

   visual_raster_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_TOTAL  (H_TOTAL),
      .V_ACTIVE (V_ACTIVE),
      .V_TOTAL  (V_TOTAL)
   ) uRaster (
      .clk_i     (iCLK),
      .rst_ni    (iRST_N),
      .pixEn_i   (iPIX_EN),
      .x_o       (oX),
      .y_o       (oY),
      .visible_o (visible),
      .wrap_o    (frameWrap)
   );

   // ------------------------------------------------------------------------
   // Audio freeze: holding regs track the latest sample; the effect-facing
   // copy only updates at a frame wrap, so a sample landing on the wrap cycle
   // itself is seen one frame later.
   // ------------------------------------------------------------------------
   audio_t holdLQ, holdRQ, audLQ, audRQ;

   // Holding and frame-frozen audio registers.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         holdLQ <= '0;
         holdRQ <= '0;
         audLQ  <= '0;
         audRQ  <= '0;
      end else begin
         if (iAUD_VALID) begin
            holdLQ <= iL;
            holdRQ <= iR;
         end
         if (frameWrap) begin
            audLQ <= holdLQ;
            audRQ <= holdRQ;
         end
      end
   end

   assign oAUD_L = audLQ;
   assign oAUD_R = audRQ;

   // ------------------------------------------------------------------------
   // Mode FSM and auto-cycle frame counter. A manual request parks in PEND
   // until the next wrap; an auto expiry on the same wrap merges into one step.
   // ------------------------------------------------------------------------
   modeState_e      stateQ, stateD;
   mode_t           modeQ, modeD;
   logic [FC_W-1:0] frameCntQ, frameCntD;
   logic            autoActive;
   logic            autoHit;

   assign autoActive = AUTO_ON && iAUTO_EN;
   assign autoHit    = autoActive && (frameCntQ == FC_LAST);

   // Next state, next mode and next frame count, evaluated every cycle.
   always_comb begin
      stateD    = stateQ;
      modeD     = modeQ;
      frameCntD = frameCntQ;
      if ((stateQ == ST_RUN) && iMODE_NEXT) begin
         stateD = ST_PEND;
      end
      if (frameWrap) begin
         if ((stateQ == ST_PEND) || autoHit) begin
            stateD    = ST_RUN;
            modeD     = nextMode(modeQ, MODE_LAST);
            frameCntD = '0;
         end else if (autoActive) begin
            frameCntD = frameCntQ + 1'b1;
         end
      end
      if (!autoActive) begin
         frameCntD = '0;
      end
   end

   // Mode FSM, mode index and frame counter registers.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         stateQ    <= ST_RUN;
         modeQ     <= MODE_0;
         frameCntQ <= '0;
      end else begin
         stateQ    <= stateD;
         modeQ     <= modeD;
         frameCntQ <= frameCntD;
      end
   end

   assign oMODE = modeQ;

   // ------------------------------------------------------------------------
   // Output mux and pixel register. Inputs past the last implemented mode are
   // tied off so they can never reach the screen.
   // ------------------------------------------------------------------------
   rgb_t selRgb;
   rgb_t rgbQ;
   logic blankNQ;
   logic frameStartQ;

   // Pick the active effect's colour for the current raster position.
   always_comb begin
      selRgb = '0;
      case (modeQ)
         MODE_0:  selRgb = iRGB_0;
         MODE_1:  selRgb = iRGB_1;
         MODE_2:  selRgb = (N_MODES > 2) ? iRGB_2 : '0;
         MODE_3:  selRgb = (N_MODES > 3) ? iRGB_3 : '0;
         default: selRgb = '0;
      endcase
   end

   // Pixel register advances with the strobe; frame-start is a one-cycle echo of the wrap.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         rgbQ        <= '0;
         blankNQ     <= 1'b0;
         frameStartQ <= 1'b0;
      end else begin
         frameStartQ <= frameWrap;
         if (iPIX_EN) begin
            blankNQ <= visible;
            rgbQ    <= visible ? selRgb : '0;
         end
      end
   end

   assign oFRAME_START = frameStartQ;
   assign oBLANK_N     = blankNQ;
   assign oVGA_R       = rgbQ[23:16];
   assign oVGA_G       = rgbQ[15:8];
   assign oVGA_B       = rgbQ[7:0];

endmodule
